// File: rtl/led_blink_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_arbiter_if
//  Purpose  : Bundle between the status requesters and the LED blink
//             arbiter.
//  Signals  : req          requester -> arbiter  per-requester request level
//             req_count    requester -> arbiter  blink count, nibble i = req i
//             half_period  requester -> arbiter  ON/OFF time in ticks
//             grant        arbiter -> requester  one-hot LED owner
//             done         arbiter -> requester  burst-complete pulse
//             busy         arbiter -> requester  arbiter not idle
//             led          arbiter -> pin        LED drive
//  Modports : master = requester side, slave = arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface led_blink_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   req;
    logic [4*N_REQ-1:0] req_count;
    logic [9:0]         half_period;
    logic [N_REQ-1:0]   grant;
    logic [N_REQ-1:0]   done;
    logic               busy;
    logic               led;

    modport master (
        output req, req_count, half_period,
        input  grant, done, busy, led
    );

    modport slave (
        input  req, req_count, half_period,
        output grant, done, busy, led
    );
endinterface
`default_nettype wire

// File: rtl/led_blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : led_blink_arbiter
//  Purpose  : Round-robin sharing of one status LED among N_REQ requesters.
//             The granted requester gets a burst of req_count blinks at a
//             half-period of half_period ticks, followed by a GAP_TICKS dark
//             gap and a one-cycle done pulse.
//  Ports    : clk    system clock
//             rst_n  asynchronous active-low reset
//             bus    led_blink_arbiter_if.slave (req, req_count, half_period
//                    in; grant, done, busy, led out)
//  Options  : LED_BLINK_ACTIVE_LOW_EN - when defined the led pin is the
//             inverse of the logical LED (idle/reset level 1).
//  Revision : 1.0 - initial release
// ============================================================================
module led_blink_arbiter #(
    parameter int CLK_HZ    = 27000000,
    parameter int TICK_HZ   = 1000,
    parameter int N_REQ     = 4,
    parameter int GAP_TICKS = 500
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    led_blink_arbiter_if.slave bus
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int IW  = $clog2(N_REQ);
    localparam int GW  = $clog2(GAP_TICKS + 1);
    localparam int TW  = (GW > 10) ? GW : 10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ON   = 3'd1,
        S_OFF  = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_pre,   w_pre_nxt;
    logic [TW-1:0]    r_tmr,   w_tmr_nxt;
    logic [3:0]       r_cnt,   w_cnt_nxt;
    logic [9:0]       r_hp,    w_hp_nxt;
    logic [IW-1:0]    r_own,   w_own_nxt;
    logic [IW-1:0]    r_last,  w_last_nxt;
    logic [N_REQ-1:0] r_grant, w_grant_nxt;
    logic [N_REQ-1:0] r_done,  w_done_nxt;

    logic             w_tick;
    logic             w_phase_end;
    logic             w_own_req;
    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_idx;
    logic [IW+1:0]    w_nib_base;
    logic [3:0]       w_cnt_lat;
    logic [9:0]       w_hp_lat;
    logic [N_REQ-1:0] w_own_1h;
    logic             w_led_on;

    assign w_tick      = (r_pre == PW'(DIV - 1));
    assign w_phase_end = w_tick && (r_tmr == TW'(1));
    assign w_own_req   = bus.req[r_own];
    assign w_own_1h    = {{(N_REQ-1){1'b0}}, 1'b1} << r_own;

    // Round-robin: first set request scanning upward from last+1 with wrap.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IW'((int'(r_last) + i) % N_REQ);
            if (!w_found && bus.req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_nib_base = {w_pick, 2'b00};
    assign w_cnt_lat  = bus.req_count[w_nib_base +: 4];
    assign w_hp_lat   = (bus.half_period == 10'd0) ? 10'd1 : bus.half_period;

    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = w_tick ? '0 : r_pre + 1'b1;
        w_tmr_nxt   = w_tick ? r_tmr - 1'b1 : r_tmr;
        w_cnt_nxt   = r_cnt;
        w_hp_nxt    = r_hp;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_grant_nxt = r_grant;
        w_done_nxt  = '0;

        case (r_state)
            S_IDLE: begin
                // Prescaler held at zero so every burst starts phase-aligned.
                w_pre_nxt = '0;
                w_tmr_nxt = r_tmr;
                if (w_found) begin
                    w_own_nxt   = w_pick;
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                    w_cnt_nxt   = w_cnt_lat;
                    w_hp_nxt    = w_hp_lat;
                    w_tmr_nxt   = TW'(w_hp_lat);
                    w_state_nxt = (w_cnt_lat == 4'd0) ? S_DONE : S_ON;
                end
            end
            S_ON, S_OFF, S_GAP: begin
                if (!w_own_req) begin
                    // Owner withdrew: release silently, no done pulse.
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_own;
                    w_pre_nxt   = '0;
                end else if (w_phase_end) begin
                    if (r_state == S_ON) begin
                        w_state_nxt = S_OFF;
                        w_cnt_nxt   = r_cnt - 1'b1;
                        w_tmr_nxt   = TW'(r_hp);
                    end else if (r_state == S_OFF) begin
                        if (r_cnt != 4'd0) begin
                            w_state_nxt = S_ON;
                            w_tmr_nxt   = TW'(r_hp);
                        end else begin
                            w_state_nxt = S_GAP;
                            w_tmr_nxt   = TW'(GAP_TICKS);
                        end
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_done_nxt  = w_own_1h;
                w_last_nxt  = r_own;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
            r_tmr   <= '0;
            r_cnt   <= '0;
            r_hp    <= 10'd1;
            r_own   <= '0;
            r_last  <= IW'(N_REQ - 1);
            r_grant <= '0;
            r_done  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_tmr   <= w_tmr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hp    <= w_hp_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_led_on  = (r_state == S_ON);
    assign bus.grant = r_grant;
    assign bus.done  = r_done;
    assign bus.busy  = (r_state != S_IDLE);

`ifdef LED_BLINK_ACTIVE_LOW_EN
    assign bus.led = ~w_led_on;
`else
    assign bus.led = w_led_on;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_blink_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_blink_arbiter
//  Purpose  : Self-checking bench for led_blink_arbiter. Expected outputs
//             come from a burst-timeline model expressed as arithmetic on
//             the cycle offset from the grant.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_blink_arbiter;
    localparam int CLK_HZ    = 1000;
    localparam int TICK_HZ   = 100;
    localparam int N_REQ     = 4;
    localparam int GAP_TICKS = 3;
    localparam int DIV       = CLK_HZ / TICK_HZ;
    localparam int OW        = 2 * N_REQ + 2;

`ifdef LED_BLINK_ACTIVE_LOW_EN
    localparam logic ACT_LOW = 1'b1;
`else
    localparam logic ACT_LOW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    led_blink_arbiter_if #(.N_REQ(N_REQ)) bus ();

    led_blink_arbiter #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .N_REQ     (N_REQ),
        .GAP_TICKS (GAP_TICKS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int phase_len(int h);
        return ((h == 0) ? 1 : h) * DIV;
    endfunction

    // Cycle offset (from the first grant cycle) of the last cycle with grant.
    function automatic int burst_last(int n, int h);
        return (n == 0) ? 0 : 2 * n * phase_len(h) + GAP_TICKS * DIV;
    endfunction

    function automatic logic led_model(int n, int h, int t);
        if (n == 0 || t < 0 || t >= 2 * n * phase_len(h)) return 1'b0;
        return ((t / phase_len(h)) % 2) == 0;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(int i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int rr_pick(logic [N_REQ-1:0] mask, int last);
        for (int i = 1; i <= N_REQ; i++)
            if (mask[(last + i) % N_REQ]) return (last + i) % N_REQ;
        return 0;
    endfunction

    // {grant, done, busy, led} expected t cycles after the grant edge.
    function automatic logic [OW-1:0] exp_out(int own, int n, int h, int t);
        logic [N_REQ-1:0] g;
        logic [N_REQ-1:0] d;
        logic             b;
        logic             l;
        int               lt;
        lt = burst_last(n, h);
        g  = (t <= lt) ? onehot(own) : '0;
        d  = (t == lt + 1) ? onehot(own) : '0;
        b  = (t <= lt);
        l  = led_model(n, h, t) ^ ACT_LOW;
        return {g, d, b, l};
    endfunction

    function automatic logic [OW-1:0] idle_out();
        return {{(2 * N_REQ + 1){1'b0}}, ACT_LOW};
    endfunction

    function automatic logic [4*N_REQ-1:0] rand_counts();
        logic [4*N_REQ-1:0] v;
        v = '0;
        for (int k = 0; k < N_REQ; k++) v[k*4 +: 4] = 4'($urandom_range(0, 3));
        return v;
    endfunction

    function automatic logic [OW-1:0] observe();
        return {bus.grant, bus.done, bus.busy, bus.led};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        bus.req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [OW-1:0] obs;
        #2;
        obs = observe();
        checks++;
        if (obs !== idle_out()) begin
            errors++;
            $display("FAIL reset_async got=%h exp=%h", obs, idle_out());
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== idle_out()) begin
            errors++;
            $display("FAIL reset_release got=%h exp=%h", obs, idle_out());
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single_burst();
        logic [OW-1:0] obs, exp;
        int lt, n_done;
        do_reset();
        bus.req = 4'b0010; bus.req_count = 16'h0020; bus.half_period = 10'd4;
        @(negedge clk);
        obs = observe();
        checks++;
        if (obs !== idle_out()) begin
            errors++;
            $display("FAIL single_latency got=%h exp=%h", obs, idle_out());
        end
        @(posedge clk); #1;
        lt     = burst_last(2, 4);
        n_done = 0;
        for (int t = 0; t <= lt + 3; t++) begin
            if (t == lt + 1) bus.req = '0;
            if (t == 7) begin
                bus.req_count = 16'hFFFF; bus.half_period = 10'd1;
            end
            @(negedge clk);
            obs = observe();
            exp = exp_out(1, 2, 4, t);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL single_burst t=%0d got=%h exp=%h", t, obs, exp);
            end
            if (bus.done[1]) n_done++;
            @(posedge clk); #1;
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL single_done_count got=%0d exp=1", n_done);
        end
    endtask

    task automatic test_round_robin();
        logic [OW-1:0]    obs, exp;
        logic [N_REQ-1:0] order [5];
        int last, own, lt;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        bus.req = 4'b1111; bus.req_count = 16'h1111; bus.half_period = 10'd1;
        @(posedge clk); #1;
        last = N_REQ - 1;
        lt   = burst_last(1, 1);
        for (int b = 0; b < 5; b++) begin
            own = rr_pick(4'b1111, last);
            for (int t = 0; t <= lt + 1; t++) begin
                @(negedge clk);
                obs = observe();
                exp = exp_out(own, 1, 1, t);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL rr_burst b=%0d t=%0d got=%h exp=%h", b, t, obs, exp);
                end
                if (t == 0) begin
                    checks++;
                    if (bus.grant !== order[b]) begin
                        errors++;
                        $display("FAIL rr_order b=%0d got=%b exp=%b", b, bus.grant, order[b]);
                    end
                end
                @(posedge clk); #1;
            end
            last = own;
        end
        bus.req = '0;
    endtask

    task automatic test_abort();
        logic [OW-1:0] obs, exp;
        do_reset();
        bus.req = 4'b1100; bus.req_count = 16'h1300; bus.half_period = 10'd4;
        @(posedge clk); #1;
        for (int t = 0; t <= 18; t++) begin
            if (t == 15) bus.req = 4'b1000;
            @(negedge clk);
            obs = observe();
            if (t <= 15)      exp = exp_out(2, 3, 4, t);
            else if (t == 16) exp = idle_out();
            else              exp = exp_out(3, 1, 4, t - 17);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL abort t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(posedge clk); #1;
        end
        bus.req = '0;
    endtask

    task automatic test_edge_values();
        logic [OW-1:0] obs, exp;
        int lt;
        do_reset();
        bus.req = 4'b0001; bus.req_count = 16'h0000; bus.half_period = 10'd5;
        @(posedge clk); #1;
        for (int t = 0; t <= 2; t++) begin
            if (t == 1) bus.req = '0;
            @(negedge clk);
            obs = observe();
            exp = exp_out(0, 0, 5, t);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL zero_count t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(posedge clk); #1;
        end
        bus.req = 4'b0010; bus.req_count = 16'h0010; bus.half_period = 10'd0;
        @(posedge clk); #1;
        lt = burst_last(1, 0);
        for (int t = 0; t <= lt + 2; t++) begin
            if (t == lt + 1) bus.req = '0;
            @(negedge clk);
            obs = observe();
            exp = exp_out(1, 1, 0, t);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL hp_zero t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [OW-1:0] obs, exp;
        do_reset();
        // Requester 0 completes a zero-count burst first, moving the
        // round-robin pointer away from its reset value.
        bus.req = 4'b0011; bus.req_count = 16'h0020; bus.half_period = 10'd2;
        @(posedge clk); #1;
        for (int t = 0; t <= 1; t++) begin
            @(negedge clk);
            obs = observe();
            exp = exp_out(0, 0, 2, t);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_pre0 t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(posedge clk); #1;
        end
        for (int t = 0; t < 25; t++) begin
            @(negedge clk);
            obs = observe();
            exp = exp_out(1, 2, 2, t);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rst_pre1 t=%0d got=%h exp=%h", t, obs, exp);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        obs = observe();
        checks++;
        if (obs !== idle_out()) begin
            errors++;
            $display("FAIL rst_async_mid got=%h exp=%h", obs, idle_out());
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        obs = observe();
        exp = exp_out(0, 0, 2, 0);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL rst_first_grant got=%h exp=%h", obs, exp);
        end
        bus.req = '0;
    endtask

    task automatic test_random();
        logic [OW-1:0]      obs, exp;
        logic [N_REQ-1:0]   mask;
        logic [4*N_REQ-1:0] lat_cnt;
        logic [9:0]         lat_hp;
        int last, own, n, h, lt;
        do_reset();
        last = N_REQ - 1;
        mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
        bus.req = mask; bus.req_count = rand_counts();
        bus.half_period = 10'($urandom_range(0, 2));
        lat_cnt = bus.req_count;
        lat_hp  = bus.half_period;
        @(posedge clk); #1;
        for (int b = 0; b < 8; b++) begin
            own = rr_pick(mask, last);
            n   = int'((lat_cnt >> (4 * own)) & 16'hF);
            h   = int'(lat_hp);
            lt  = burst_last(n, h);
            for (int t = 0; t <= lt + 1; t++) begin
                bus.req_count   = rand_counts();
                bus.half_period = 10'($urandom_range(0, 2));
                if (t == lt + 1) begin
                    mask    = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
                    bus.req = mask;
                end
                @(negedge clk);
                obs = observe();
                exp = exp_out(own, n, h, t);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL random b=%0d t=%0d got=%h exp=%h", b, t, obs, exp);
                end
                @(posedge clk); #1;
            end
            lat_cnt = bus.req_count;
            lat_hp  = bus.half_period;
            last    = own;
        end
        bus.req = '0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req         = '0;
        bus.req_count   = '0;
        bus.half_period = '0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_abort();
        test_edge_values();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
